// File: rtl/nn_infer_scheduler.sv
// nn_infer_scheduler: round-robin arbiter sharing one NN inference engine
// between NUM_REQ frame requesters. Drives the engine's level start/done
// handshake, tags each result with its owner and watches job duration.
// Optional build macro NN_SCHED_PERF_EN adds the last_latency output.
module nn_infer_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               eng_start,
  input  logic               eng_done,
  output logic               busy,
  output logic               result_valid,
  output logic [ID_W-1:0]    result_id,
  output logic               result_err,
  output logic               timeout_err
`ifdef NN_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]   last_latency
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]    ID_ONE    = {{(ID_W-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]      REQ_COUNT = (ID_W+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] GRANT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_t             state_r, state_s;
  logic [ID_W-1:0]    rr_ptr_r, rr_ptr_s;
  logic [NUM_REQ-1:0] grant_r, grant_s;
  logic               eng_start_r, eng_start_s;
  logic               busy_r, busy_s;
  logic               result_valid_r, result_valid_s;
  logic [ID_W-1:0]    result_id_r, result_id_s;
  logic               result_err_r, result_err_s;
  logic               timeout_err_r, timeout_err_s;
  logic [CNT_W-1:0]   wd_cnt_r, wd_cnt_s;
  logic               err_flag_r, err_flag_s;
  logic [ID_W-1:0]    winner_s;
  logic               found_s;
  logic [ID_W:0]      arb_idx_s;
`ifdef NN_SCHED_PERF_EN
  logic [CNT_W-1:0]   last_latency_r, last_latency_s;
`endif

  // Round-robin search: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    winner_s  = {ID_W{1'b0}};
    found_s   = 1'b0;
    arb_idx_s = {(ID_W+1){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx_s = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
      if (arb_idx_s >= REQ_COUNT) begin
        arb_idx_s = arb_idx_s - REQ_COUNT;
      end else begin
        arb_idx_s = arb_idx_s;
      end
      if (!found_s && req[arb_idx_s[ID_W-1:0]]) begin
        found_s  = 1'b1;
        winner_s = arb_idx_s[ID_W-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_s        = state_r;
    rr_ptr_s       = rr_ptr_r;
    grant_s        = grant_r;
    eng_start_s    = eng_start_r;
    result_id_s    = result_id_r;
    wd_cnt_s       = wd_cnt_r;
    err_flag_s     = err_flag_r;
    result_valid_s = 1'b0;
    result_err_s   = 1'b0;
    timeout_err_s  = 1'b0;
`ifdef NN_SCHED_PERF_EN
    last_latency_s = last_latency_r;
`endif
    case (state_r)
      IDLE: begin
        // A done level seen here is spurious and deliberately ignored.
        if (found_s) begin
          grant_s     = GRANT_LSB << winner_s;
          result_id_s = winner_s;
          eng_start_s = 1'b1;
          wd_cnt_s    = {CNT_W{1'b0}};
          err_flag_s  = 1'b0;
          state_s     = WAIT;
          if (winner_s == ID_LAST) begin
            rr_ptr_s = {ID_W{1'b0}};
          end else begin
            rr_ptr_s = winner_s + ID_ONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        wd_cnt_s = sat_inc(wd_cnt_r);
        // Done takes priority over a watchdog expiry in the same cycle.
        if (eng_done) begin
          eng_start_s    = 1'b0;
          result_valid_s = 1'b1;
          result_err_s   = err_flag_r;
          state_s        = DRAIN;
`ifdef NN_SCHED_PERF_EN
          last_latency_s = sat_inc(wd_cnt_r);
`endif
        end else if (wd_cnt_r == WD_LAST) begin
          // The engine cannot be aborted: flag the job and keep waiting.
          timeout_err_s = 1'b1;
          err_flag_s    = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      DRAIN: begin
        // Hold the grant until the engine has dropped done, so the next
        // start never overlaps the previous job's done level.
        if (!eng_done) begin
          grant_s = {NUM_REQ{1'b0}};
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s     = IDLE;
        grant_s     = {NUM_REQ{1'b0}};
        eng_start_s = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      rr_ptr_r       <= {ID_W{1'b0}};
      grant_r        <= {NUM_REQ{1'b0}};
      eng_start_r    <= 1'b0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      result_id_r    <= {ID_W{1'b0}};
      result_err_r   <= 1'b0;
      timeout_err_r  <= 1'b0;
      wd_cnt_r       <= {CNT_W{1'b0}};
      err_flag_r     <= 1'b0;
`ifdef NN_SCHED_PERF_EN
      last_latency_r <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r        <= state_s;
      rr_ptr_r       <= rr_ptr_s;
      grant_r        <= grant_s;
      eng_start_r    <= eng_start_s;
      busy_r         <= busy_s;
      result_valid_r <= result_valid_s;
      result_id_r    <= result_id_s;
      result_err_r   <= result_err_s;
      timeout_err_r  <= timeout_err_s;
      wd_cnt_r       <= wd_cnt_s;
      err_flag_r     <= err_flag_s;
`ifdef NN_SCHED_PERF_EN
      last_latency_r <= last_latency_s;
`endif
    end
  end

  assign grant        = grant_r;
  assign eng_start    = eng_start_r;
  assign busy         = busy_r;
  assign result_valid = result_valid_r;
  assign result_id    = result_id_r;
  assign result_err   = result_err_r;
  assign timeout_err  = timeout_err_r;
`ifdef NN_SCHED_PERF_EN
  assign last_latency = last_latency_r;
`endif

endmodule

// File: tb/tb_nn_infer_scheduler.sv
// Testbench for nn_infer_scheduler: directed and randomized jobs against a
// round-robin reference model, with a behavioural NN engine that raises done
// N cycles after start and drops it one cycle after start falls.
module tb_nn_infer_scheduler;

  localparam int NREQ = 4;
  localparam int TO   = 16;
  localparam int CW   = 20;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            eng_start;
  logic            eng_done;
  logic            busy;
  logic            result_valid;
  logic [1:0]      result_id;
  logic            result_err;
  logic            timeout_err;
`ifdef NN_SCHED_PERF_EN
  logic [CW-1:0]   last_latency;
`endif

  int tests = 0;
  int fails = 0;
  int model_ptr = 0;
  int eng_n = 5;
  int eng_cnt = 0;
  logic eng_model = 1'b0;
  logic eng_spur = 1'b0;
  logic low_seen = 1'b0;

  assign eng_done = eng_model | eng_spur;

  nn_infer_scheduler #(
    .NUM_REQ(NREQ), .ID_W(2), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .eng_start(eng_start), .eng_done(eng_done), .busy(busy),
    .result_valid(result_valid), .result_id(result_id),
    .result_err(result_err), .timeout_err(timeout_err)
`ifdef NN_SCHED_PERF_EN
    , .last_latency(last_latency)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: done rises eng_n cycles after start is first seen.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        eng_model = 1'b0;
        eng_cnt   = 0;
        low_seen  = 1'b0;
      end else if (eng_start) begin
        low_seen = 1'b0;
        if (!eng_model) begin
          if (eng_cnt == eng_n) eng_model = 1'b1;
          else eng_cnt++;
        end
      end else begin
        eng_cnt = 0;
        if (low_seen) eng_model = 1'b0;
        low_seen = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: first set request at or after ptr, modulo NREQ.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (ptr + i) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // One complete job: request at an IDLE cycle, follow it until grant clears.
  task automatic do_job(input logic [NREQ-1:0] req_v, input int n, input bit scramble);
    int exp_w, c, to_cnt, to_cyc, rv_cnt, rv_cyc, bad;
    logic rv_err;
    logic [NREQ-1:0] oh;
    bit exp_to;
    exp_w  = rr_pick(req_v, model_ptr);
    oh     = 4'b0001 << exp_w;
    exp_to = (n >= TO);
    eng_n  = n;
    req    = req_v;
    @(posedge clk);
    #1;
    chk("grant", 32'(grant), 32'(oh));
    chk("eng_start", 32'(eng_start), 32'd1);
    chk("busy", 32'(busy), 32'd1);
    chk("result_id", 32'(result_id), 32'(exp_w));
    chk("start_over_done", 32'(eng_done), 32'd0);
    model_ptr = (exp_w + 1) % NREQ;
    if (scramble) req = 4'($urandom_range(0, 15));
    c = 0; to_cnt = 0; to_cyc = 0; rv_cnt = 0; rv_cyc = 0; bad = 0; rv_err = 1'b0;
    while (grant !== 4'b0000 && c < n + 40) begin
      @(posedge clk);
      #1;
      c++;
      if (timeout_err) begin to_cnt++; to_cyc = c; end
      if (result_valid) begin rv_cnt++; rv_cyc = c; rv_err = result_err; end
      else if (result_err) bad++;
      if (grant !== oh && grant !== 4'b0000) bad++;
      if (result_id !== 2'(exp_w)) bad++;
      if (grant !== 4'b0000 && busy !== 1'b1) bad++;
    end
    chk("timeout_count", 32'(to_cnt), exp_to ? 32'd1 : 32'd0);
    chk("timeout_cycle", 32'(to_cyc), exp_to ? 32'(TO) : 32'd0);
    chk("result_count", 32'(rv_cnt), 32'd1);
    chk("result_cycle", 32'(rv_cyc), 32'(n + 1));
    chk("result_err", 32'(rv_err), 32'(exp_to));
    chk("grant_release_cycle", 32'(c), 32'(n + 3));
    chk("busy_after", 32'(busy), 32'd0);
    chk("result_id_held", 32'(result_id), 32'(exp_w));
    chk("in_job_glitches", 32'(bad), 32'd0);
`ifdef NN_SCHED_PERF_EN
    chk("last_latency", 32'(last_latency), 32'(n + 1));
`endif
  endtask

  initial begin
    int rv, n, exp_w;
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_id", 32'(result_id), 32'd0);
    chk("rst_err", 32'(result_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
`ifdef NN_SCHED_PERF_EN
    chk("rst_latency", 32'(last_latency), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin with all requests held: expected order 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      chk("rr_order", 32'(rr_pick(4'b1111, model_ptr)), 32'(j % NREQ));
      do_job(4'b1111, 4, 1'b0);
    end
    // Single requester, then wrap/skip from rr_ptr=3.
    do_job(4'b0100, 5, 1'b0);
    do_job(4'b0011, 5, 1'b0);
    do_job(4'b0011, 5, 1'b0);
    // Timeout job, clean follow-up, and done on the watchdog cycle.
    do_job(4'b1000, 20, 1'b1);
    do_job(4'b1000, 5, 1'b1);
    do_job(4'b0110, TO - 1, 1'b1);
    do_job(4'b0110, TO, 1'b1);

    // Spurious done while idle must be ignored.
    req = 4'b0000;
    eng_spur = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      chk("spur_valid", 32'(result_valid), 32'd0);
      chk("spur_busy", 32'(busy), 32'd0);
    end
    eng_spur = 1'b0;
    @(posedge clk);
    #1;

    // Randomized jobs against the reference model.
    for (int j = 0; j < 14; j++) begin
      rv = int'($urandom_range(0, 15));
      n  = int'($urandom_range(1, 24));
      if (rv == 0) begin
        req = 4'b0000;
        @(posedge clk);
        #1;
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
      end else begin
        do_job(4'(rv), n, 1'b1);
      end
    end

    // Reset in the middle of WAIT.
    req   = 4'b0100;
    eng_n = 20;
    exp_w = rr_pick(req, model_ptr);
    @(posedge clk);
    #1;
    chk("pre_rst_grant", 32'(grant), 32'(4'b0001 << exp_w));
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_start", 32'(eng_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0000;
    model_ptr = 0;
`ifdef NN_SCHED_PERF_EN
    chk("midrst_latency", 32'(last_latency), 32'd0);
`endif
    chk("post_rst_pick", 32'(rr_pick(4'b0001, model_ptr)), 32'd0);
    do_job(4'b0001, 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_infer_scheduler.md
Name: nn_infer_scheduler

Overview:
- Shares the single hazard-detection NN inference engine between NUM_REQ frame requesters, such as camera tiles or sensor ports.
- Arbitrates round-robin, drives the engine's level start/done handshake, and reports which requester each result belongs to.
- Provides a watchdog on inference duration.
- Sits between the frame-capture front ends and the NN engine; the winning requester's pixel bus is muxed to the engine using `grant`.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of result_id; must equal ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 65535, cycles in WAIT before timeout_err fires (>=2).
- CNT_W, 20, width of the watchdog/latency counters; must hold TIMEOUT_CYCLES.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous, active-high reset.
- req, in, NUM_REQ, per-requester level request; held until granted.
- grant, out, NUM_REQ, one-hot; selects the pixel source feeding the engine.
- eng_start, out, 1, engine start level.
- eng_done, in, 1, engine done level.
- busy, out, 1, high whenever state != IDLE.
- result_valid, out, 1, one-cycle pulse when the engine's outputs are valid.
- result_id, out, ID_W, index of the requester that owns the current or last job.
- result_err, out, 1, qualifies result_valid; set if the job exceeded TIMEOUT_CYCLES.
- timeout_err, out, 1, one-cycle pulse when the watchdog expires.

Behaviour:
- Reset values: every output is 0. Internal state: IDLE, rr_ptr=0, wd_cnt=0, err_flag=0.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - If |req, pick the first asserted req at or after rr_ptr, searching upward with wrap modulo NUM_REQ.
  - Next cycle: grant=onehot(winner), result_id=winner, eng_start=1, wd_cnt=0, err_flag=0, state=WAIT.
  - Request-to-grant/start latency is 1 cycle.
- rr_ptr update: set to winner+1 (wrapping to 0 after NUM_REQ-1) when the grant issues.
- WAIT: wd_cnt increments by 1 each cycle and saturates.
  - When wd_cnt == TIMEOUT_CYCLES-1 and eng_done=0: pulse timeout_err for one cycle and set err_flag. Stay in WAIT; the engine cannot be aborted.
  - When eng_done=1: eng_start<=0, result_valid pulses for 1 cycle, result_err<=err_flag (with result_valid only), state=DRAIN.
  - If timeout and done coincide in the same cycle, done wins: no timeout_err, result_err=0.
- DRAIN: eng_start stays low and grant is held. When eng_done==0: grant<=0, state=IDLE.
  - This guarantees the engine has returned to its idle state before the next start, so there is no back-to-back start glitch.
- Requester handshake:
  - A requester must hold req until its grant bit is seen.
  - req changes during WAIT/DRAIN are ignored; the job in flight always completes.
  - A requester that drops req before being granted is simply skipped.
- Minimum turnaround between consecutive grants: the cycle done rises, plus the DRAIN exit cycle, plus the IDLE arbitration cycle.
- result_id holds its value until the next grant.
- Reset mid-operation: all outputs return to 0 asynchronously. The engine is reset by the same rst.
- eng_done high while in IDLE (spurious): ignored, with no result_valid.

Optional Feature:
- Macro: NN_SCHED_PERF_EN.
- Defined: adds output port last_latency [CNT_W-1:0]. On each result_valid it loads the cycle count from the grant cycle to the done-detect cycle inclusive (wd_cnt+1, saturating). Resets to 0.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan (NUM_REQ=4, TIMEOUT_CYCLES=16, engine model asserts done N cycles after start and drops it 1 cycle after start falls):
- Single request: req=4'b0100, N=5.
  - grant=4'b0100 and eng_start=1 one cycle later.
  - result_valid one cycle with result_id=2, result_err=0.
  - grant clears after done falls; busy low afterwards.
- Round-robin: req=4'b1111 held for all jobs.
  - Grant order is 0,1,2,3,0.
  - eng_start is never high while eng_done is still high from the previous job.
- Wrap/skip: rr_ptr=3 after a grant to 2; req=4'b0011.
  - Next grant goes to 0, then to 1.
- Timeout: N=20.
  - timeout_err pulses exactly once, 16 cycles after grant.
  - result_valid later arrives with result_err=1; the next job has result_err=0.
- Coincidence: N chosen so done rises on the watchdog cycle.
  - No timeout_err; result_err=0.
- Reset mid-WAIT: assert rst.
  - grant, eng_start, busy, and result_valid are 0 immediately.
  - After release, req=4'b0001 is granted to 0.
  - With NN_SCHED_PERF_EN defined, last_latency=0 after reset, and equals 6 for an N=5 job.
